l1_dram_arbiter: RTL

Two-requester arbiter and sequencer that shares the single 256-bit DRAM port between the L1 data cache (requester 0) and the L1 instruction cache (requester 1). Each L1 cache controller drives its block-sized cs/we/ack transaction into this block exactly as it would drive DRAM directly. The arbiter picks one requester, registers its address, command and write line, runs the DRAM handshake, and returns the read line with a one-cycle ack. It sits between the L1 caches and the DRAM model in the top-level CPU wrapper.

---
 rtl/l1_dram_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/l1_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l1_dram_arbiter
// Description : Shares one 256-bit DRAM port between the L1 D-cache (m0) and
//               the L1 I-cache (m1). Optional macro ARB_ROUND_ROBIN_EN selects
//               round-robin tie-breaking instead of fixed m0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_dram_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    input  logic                      m0_cs,
    input  logic                      m0_we,
    input  logic [MEM_DATA_WIDTH-1:0] m0_data_i,
    output logic                      m0_ack,
    output logic [MEM_DATA_WIDTH-1:0] m0_data_o,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic                      m1_cs,
    input  logic                      m1_we,
    input  logic [MEM_DATA_WIDTH-1:0] m1_data_i,
    output logic                      m1_ack,
    output logic [MEM_DATA_WIDTH-1:0] m1_data_o,
    output logic [ADDR_WIDTH-1:0]     dram_addr,
    output logic                      dram_cs,
    output logic                      dram_we,
    input  logic                      dram_ack,
    input  logic [MEM_DATA_WIDTH-1:0] dram_data_i,
    output logic [MEM_DATA_WIDTH-1:0] dram_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_owner;
    logic                      w_owner_nxt;
    logic [MEM_DATA_WIDTH-1:0] r_line;
    logic [MEM_DATA_WIDTH-1:0] w_line_nxt;
    logic [ADDR_WIDTH-1:0]     w_addr_nxt;
    logic [MEM_DATA_WIDTH-1:0] w_wdata_nxt;
    logic                      w_cs_nxt;
    logic                      w_we_nxt;
    logic                      w_ack0_nxt;
    logic                      w_ack1_nxt;
    logic                      w_grant1;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last names the requester granted most recently; resets to m1 so m0 wins the first tie
    logic r_last;
    logic w_last_nxt;

    assign w_grant1 = m1_cs & (~m0_cs | ~r_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else begin
            r_last <= w_last_nxt;
        end
    end
`else
    assign w_grant1 = m1_cs & ~m0_cs;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_line_nxt  = r_line;
        w_addr_nxt  = dram_addr;
        w_wdata_nxt = dram_data_o;
        w_cs_nxt    = dram_cs;
        w_we_nxt    = dram_we;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            IDLE: begin
                if (m0_cs || m1_cs) begin
                    w_owner_nxt = w_grant1;
                    w_addr_nxt  = w_grant1 ? m1_addr   : m0_addr;
                    w_we_nxt    = w_grant1 ? m1_we     : m0_we;
                    w_wdata_nxt = w_grant1 ? m1_data_i : m0_data_i;
                    w_cs_nxt    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (dram_ack) begin
                    w_cs_nxt    = 1'b0;
                    w_state_nxt = DONE;
                    // Ack is registered here so it is high for exactly the DONE cycle
                    w_ack0_nxt  = ~r_owner;
                    w_ack1_nxt  = r_owner;
                    if (!dram_we) begin
                        w_line_nxt = dram_data_i;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                w_last_nxt  = r_owner;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_cs_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_line      <= '0;
            dram_addr   <= '0;
            dram_data_o <= '0;
            dram_cs     <= 1'b0;
            dram_we     <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_line      <= w_line_nxt;
            dram_addr   <= w_addr_nxt;
            dram_data_o <= w_wdata_nxt;
            dram_cs     <= w_cs_nxt;
            dram_we     <= w_we_nxt;
            m0_ack      <= w_ack0_nxt;
            m1_ack      <= w_ack1_nxt;
        end
    end

    assign m0_data_o = r_line;
    assign m1_data_o = r_line;

endmodule
`default_nettype wire
